// File: rtl/wave_resynth.sv
// Two-channel phase-accumulator waveform resynthesiser (parabolic sine / triangle)
// producing per-channel samples and their sum, one sample per sample_en strobe.
module wave_resynth #(
  parameter int LOG2_N = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     stop,
  input  logic [LOG2_N-1:0]        idx1,
  input  logic [LOG2_N-1:0]        idx2,
  input  logic [1:0]               type1,
  input  logic [1:0]               type2,
  input  logic                     sample_en,
  output logic signed [11:0]       out1,
  output logic signed [11:0]       out2,
  output logic signed [12:0]       sum_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     frame_pulse,
  output logic                     alias_err
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [11:0] sine_map(input logic [11:0] a);
    logic [10:0] h;
    logic [20:0] prod;
    logic [11:0] m;
    h        = a[10:0];
    prod     = 21'(h) * 21'(11'd2047 - h);
    m        = 12'(prod >> 10);
    sine_map = a[11] ? (12'd0 - m) : m;
  endfunction

  function automatic logic [11:0] tri_map(input logic [11:0] a);
    logic [11:0] t;
    t       = a[11] ? (12'd4095 - a) : a;
    tri_map = t - 12'd1024;
  endfunction

  function automatic logic is_muted(input logic [1:0] typ, input logic [LOG2_N-1:0] idx);
    is_muted = (typ == 2'd0) || (typ == 2'd3) || (idx == {LOG2_N{1'b0}}) || idx[LOG2_N-1];
  endfunction

  function automatic logic [11:0] wave_map(input logic [1:0] typ, input logic muted,
                                           input logic [11:0] a);
    logic [11:0] r;
    r = 12'd0;
    if (muted) begin
      r = 12'd0;
    end else begin
      case (typ)
        2'd1:    r = sine_map(a);
        2'd2:    r = tri_map(a);
        default: r = 12'd0;
      endcase
    end
    wave_map = r;
  endfunction

  state_t              state_r;
  logic [LOG2_N-1:0]   idx1_r, idx2_r;
  logic [1:0]          type1_r, type2_r;
  logic [31:0]         phase1_r, phase2_r;
  logic [LOG2_N-1:0]   frame_r;

  logic                load_acc_s;
  logic                step_s;
  logic [31:0]         inc1_s, inc2_s;
  logic [11:0]         wave1_s, wave2_s;

  // Stop has priority over load; a sample is only taken when neither is present.
  assign load_acc_s = load & ~stop;
  assign step_s     = (state_r == ST_RUN) & sample_en & ~load & ~stop;
  assign inc1_s     = {idx1_r, {(32-LOG2_N){1'b0}}};
  assign inc2_s     = {idx2_r, {(32-LOG2_N){1'b0}}};
  assign wave1_s    = wave_map(type1_r, is_muted(type1_r, idx1_r), phase1_r[31:20]);
  assign wave2_s    = wave_map(type2_r, is_muted(type2_r, idx2_r), phase2_r[31:20]);

  // Latched channel configuration and the sticky alias flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx1_r    <= {LOG2_N{1'b0}};
      idx2_r    <= {LOG2_N{1'b0}};
      type1_r   <= 2'd0;
      type2_r   <= 2'd0;
      alias_err <= 1'b0;
    end else if (load_acc_s) begin
      idx1_r    <= idx1;
      idx2_r    <= idx2;
      type1_r   <= type1;
      type2_r   <= type2;
      alias_err <= alias_err | idx1[LOG2_N-1] | idx2[LOG2_N-1];
    end
  end

  // Run/idle control, phase accumulation and registered sample outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      phase1_r    <= 32'd0;
      phase2_r    <= 32'd0;
      frame_r     <= {LOG2_N{1'b0}};
      out1        <= 12'sd0;
      out2        <= 12'sd0;
      sum_out     <= 13'sd0;
      out_valid   <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      out_valid   <= step_s;
      frame_pulse <= step_s && (frame_r == {LOG2_N{1'b1}});
      case (state_r)
        ST_IDLE: begin
          if (load_acc_s) begin
            state_r  <= ST_RUN;
            busy     <= 1'b1;
            phase1_r <= 32'd0;
            phase2_r <= 32'd0;
            frame_r  <= {LOG2_N{1'b0}};
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            phase1_r <= 32'd0;
            phase2_r <= 32'd0;
            frame_r  <= {LOG2_N{1'b0}};
            out1     <= 12'sd0;
            out2     <= 12'sd0;
            sum_out  <= 13'sd0;
          end else if (load) begin
            phase1_r <= 32'd0;
            phase2_r <= 32'd0;
            frame_r  <= {LOG2_N{1'b0}};
          end else if (sample_en) begin
            out1     <= wave1_s;
            out2     <= wave2_s;
            sum_out  <= {wave1_s[11], wave1_s} + {wave2_s[11], wave2_s};
            phase1_r <= phase1_r + inc1_s;
            phase2_r <= phase2_r + inc2_s;
            frame_r  <= frame_r + LOG2_N'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
